hwpe_switch_ctrl: RTL and testbench

//  Sequencing controller for a multi-HWPE cluster subsystem. Replaces direct static use of the HWPE select:
//  a select/enable change is applied only once the current HWPE has drained its outstanding TCDM reads, is not

---
 rtl/hwpe_switch_ctrl_pkg.sv | 18 +
 rtl/hwpe_outstd_cnt.sv | 45 ++++
 rtl/hwpe_switch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hwpe_switch_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_switch_ctrl_pkg.sv
// Shared types and helpers for the HWPE switch sequencing controller.
package hwpe_switch_ctrl_pkg;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        RUN    = 3'd1,
        DRAIN  = 3'd2,
        GATE   = 3'd3,
        SETTLE = 3'd4,
        CLEAR  = 3'd5
    } hwpe_sw_state_e;

    // Index width for n entries; a single entry still needs one bit.
    function automatic int unsigned sw_sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hwpe_outstd_cnt.sv
// Saturating up/down counter of outstanding TCDM reads with a sticky
// over/underflow flag.
module hwpe_outstd_cnt #(
    parameter int unsigned  MAX_OUTSTD = 8,
    localparam int unsigned CNT_W      = $clog2(MAX_OUTSTD + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (inc_i && !dec_i) begin
            if (cnt_q == CNT_W'(MAX_OUTSTD)) err_d = 1'b1;
            else                             cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/hwpe_switch_ctrl.sv
// Sequences HWPE select/enable changes: drains the committed HWPE, gates all
// clocks, settles, optionally soft-clears, then re-enables the new HWPE.
module hwpe_switch_ctrl
    import hwpe_switch_ctrl_pkg::*;
#(
    parameter int unsigned  N_HWPES         = 2,
    parameter int unsigned  MAX_OUTSTD      = 8,
    parameter int unsigned  SETTLE_CYCLES   = 2,
    parameter bit           CLEAR_ON_SWITCH = 1'b1,
    localparam int unsigned SEL_W           = sw_sel_w(N_HWPES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hwpe_en_i,
    input  logic [SEL_W-1:0]   hwpe_sel_i,
    input  logic [N_HWPES-1:0] busy_i,
    input  logic               tcdm_req_i,
    input  logic               tcdm_gnt_i,
    input  logic               tcdm_wen_i,
    input  logic               tcdm_r_valid_i,
    input  logic               cfg_req_i,
    input  logic               cfg_gnt_i,
    input  logic               cfg_r_valid_i,
    output logic [N_HWPES-1:0] clk_en_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic [N_HWPES-1:0] clear_o,
    output logic               cfg_stall_o,
    output logic               switching_o,
    output logic               outstd_err_o
);

    localparam int unsigned CNT_W       = $clog2(MAX_OUTSTD + 1);
    localparam int unsigned ST_W        = sw_sel_w(SETTLE_CYCLES);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);

    hwpe_sw_state_e     state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               tgt_on_q, tgt_on_d;
    logic [SEL_W-1:0]   tgt_sel_q, tgt_sel_d;
    logic [ST_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic               cfg_pend_q, cfg_pend_d;
    logic [N_HWPES-1:0] clk_en_q, clk_en_d;
    logic [N_HWPES-1:0] clear_q, clear_d;
    logic               cfg_stall_q, cfg_stall_d;
    logic               switching_q, switching_d;

    logic [CNT_W-1:0]   outstd_cnt;
    logic               want_on;
    logic [SEL_W-1:0]   want_sel;
    logic               idle;

    hwpe_outstd_cnt #(
        .MAX_OUTSTD(MAX_OUTSTD)
    ) i_outstd_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (tcdm_req_i & tcdm_gnt_i & tcdm_wen_i),
        .dec_i (tcdm_r_valid_i),
        .cnt_o (outstd_cnt),
        .err_o (outstd_err_o)
    );

    // An out-of-range index is a request to switch everything off.
    if (N_HWPES == 1) begin : g_single
        assign want_on  = hwpe_en_i;
        assign want_sel = '0;
    end else begin : g_multi
        assign want_on  = hwpe_en_i & (32'(hwpe_sel_i) < N_HWPES);
        assign want_sel = hwpe_sel_i;
    end

    assign idle       = ~busy_i[sel_q] & (outstd_cnt == '0) & ~cfg_pend_q;
    assign cfg_pend_d = (cfg_req_i & cfg_gnt_i & ~cfg_stall_q) | (cfg_pend_q & ~cfg_r_valid_i);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        tgt_on_d     = tgt_on_q;
        tgt_sel_d    = tgt_sel_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            OFF: begin
                if (want_on) begin
                    state_d      = SETTLE;
                    sel_d        = want_sel;
                    settle_cnt_d = '0;
                end
            end
            RUN: begin
                if (!want_on || want_sel != sel_q) state_d = DRAIN;
            end
            DRAIN: begin
                tgt_on_d  = want_on;
                tgt_sel_d = want_sel;
                if (idle) state_d = GATE;
            end
            GATE: begin
                if (!tgt_on_q) begin
                    state_d = OFF;
                end else begin
                    state_d      = SETTLE;
                    sel_d        = tgt_sel_q;
                    settle_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt_q != ST_LAST) begin
                    settle_cnt_d = settle_cnt_q + ST_W'(1);
                end else if (!want_on) begin
                    state_d = OFF;
                end else if (want_sel != sel_q) begin
                    // Clocks are still all gated, so the select may move here.
                    sel_d        = want_sel;
                    settle_cnt_d = '0;
                end else begin
                    state_d = CLEAR_ON_SWITCH ? CLEAR : RUN;
                end
            end
            CLEAR:   state_d = RUN;
            default: state_d = OFF;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        clk_en_d = '0;
        clear_d  = '0;
        if (state_d == RUN || state_d == DRAIN || state_d == CLEAR) clk_en_d = N_HWPES'(1) << sel_d;
        if (state_d == CLEAR) clear_d = clk_en_d;
        cfg_stall_d = (state_d != RUN);
        switching_d = (state_d != RUN) && (state_d != OFF);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= OFF;
            sel_q        <= '0;
            tgt_on_q     <= 1'b0;
            tgt_sel_q    <= '0;
            settle_cnt_q <= '0;
            cfg_pend_q   <= 1'b0;
            clk_en_q     <= '0;
            clear_q      <= '0;
            cfg_stall_q  <= 1'b1;
            switching_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            tgt_on_q     <= tgt_on_d;
            tgt_sel_q    <= tgt_sel_d;
            settle_cnt_q <= settle_cnt_d;
            cfg_pend_q   <= cfg_pend_d;
            clk_en_q     <= clk_en_d;
            clear_q      <= clear_d;
            cfg_stall_q  <= cfg_stall_d;
            switching_q  <= switching_d;
        end
    end

    assign clk_en_o    = clk_en_q;
    assign sel_o       = sel_q;
    assign clear_o     = clear_q;
    assign cfg_stall_o = cfg_stall_q;
    assign switching_o = switching_q;

endmodule

// File: tb/tb_hwpe_switch_ctrl.sv
// Self-checking bench for hwpe_switch_ctrl: directed scenarios plus random
// traffic, all checked against a cycle-level reference model.
module tb_hwpe_switch_ctrl;

    localparam int N      = 2;
    localparam int MAXO   = 8;
    localparam int SETTLE = 2;

    localparam int M_OFF = 0, M_RUN = 1, M_DRAIN = 2, M_GATE = 3, M_SETTLE = 4, M_CLEAR = 5;

    logic         clk = 1'b0;
    logic         rst_i, hwpe_en_i;
    logic [0:0]   hwpe_sel_i;
    logic [N-1:0] busy_i;
    logic         tcdm_req_i, tcdm_gnt_i, tcdm_wen_i, tcdm_r_valid_i;
    logic         cfg_req_i, cfg_gnt_i, cfg_r_valid_i;
    logic [N-1:0] clk_en_o, clear_o;
    logic [0:0]   sel_o;
    logic         cfg_stall_o, switching_o, outstd_err_o;
    logic [7:0]   dut_vec;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    int m_mode, m_sel, m_tgt_on, m_tgt_sel, m_settle_left, m_outstd;
    bit m_err, m_pend;

    hwpe_switch_ctrl #(
        .N_HWPES(N), .MAX_OUTSTD(MAXO), .SETTLE_CYCLES(SETTLE), .CLEAR_ON_SWITCH(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .hwpe_en_i(hwpe_en_i), .hwpe_sel_i(hwpe_sel_i),
        .busy_i(busy_i), .tcdm_req_i(tcdm_req_i), .tcdm_gnt_i(tcdm_gnt_i),
        .tcdm_wen_i(tcdm_wen_i), .tcdm_r_valid_i(tcdm_r_valid_i),
        .cfg_req_i(cfg_req_i), .cfg_gnt_i(cfg_gnt_i), .cfg_r_valid_i(cfg_r_valid_i),
        .clk_en_o(clk_en_o), .sel_o(sel_o), .clear_o(clear_o),
        .cfg_stall_o(cfg_stall_o), .switching_o(switching_o), .outstd_err_o(outstd_err_o)
    );

    always #5 clk = ~clk;

    assign dut_vec = {clk_en_o, sel_o, clear_o, cfg_stall_o, switching_o, outstd_err_o};

    function automatic logic [7:0] exp_vec();
        logic [1:0] en, clr;
        logic       stall, sw;
        en    = (m_mode == M_RUN || m_mode == M_DRAIN || m_mode == M_CLEAR) ? 2'(1 << m_sel) : 2'b00;
        clr   = (m_mode == M_CLEAR) ? en : 2'b00;
        stall = (m_mode != M_RUN);
        sw    = (m_mode != M_RUN) && (m_mode != M_OFF);
        return {en, 1'(m_sel), clr, stall, sw, m_err};
    endfunction

    // Advances the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit want, idle, inc, dec, stall;
        int wsel;
        if (rst_i) begin
            m_mode = M_OFF; m_sel = 0; m_tgt_on = 0; m_tgt_sel = 0;
            m_settle_left = 0; m_outstd = 0; m_err = 0; m_pend = 0;
        end else begin
            wsel  = int'(hwpe_sel_i);
            want  = hwpe_en_i && (wsel < N);
            stall = (m_mode != M_RUN);
            idle  = !busy_i[m_sel] && (m_outstd == 0) && !m_pend;
            inc   = tcdm_req_i && tcdm_gnt_i && tcdm_wen_i;
            dec   = tcdm_r_valid_i;
            if (inc && !dec) begin
                if (m_outstd == MAXO) m_err = 1; else m_outstd++;
            end else if (dec && !inc) begin
                if (m_outstd == 0) m_err = 1; else m_outstd--;
            end
            if (cfg_req_i && cfg_gnt_i && !stall) m_pend = 1;
            else if (cfg_r_valid_i)               m_pend = 0;
            case (m_mode)
                M_OFF:   if (want) begin m_mode = M_SETTLE; m_sel = wsel; m_settle_left = SETTLE; end
                M_RUN:   if (!want || wsel != m_sel) m_mode = M_DRAIN;
                M_DRAIN: begin
                    m_tgt_on = want; m_tgt_sel = wsel;
                    if (idle) m_mode = M_GATE;
                end
                M_GATE: begin
                    if (m_tgt_on == 0) m_mode = M_OFF;
                    else begin m_mode = M_SETTLE; m_sel = m_tgt_sel; m_settle_left = SETTLE; end
                end
                M_SETTLE: begin
                    m_settle_left--;
                    if (m_settle_left == 0) begin
                        if (!want)             m_mode = M_OFF;
                        else if (wsel != m_sel) begin m_sel = wsel; m_settle_left = SETTLE; end
                        else                   m_mode = M_CLEAR;
                    end
                end
                default: m_mode = M_RUN;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        busy_i = '0; tcdm_req_i = 0; tcdm_gnt_i = 0; tcdm_wen_i = 0; tcdm_r_valid_i = 0;
        cfg_req_i = 0; cfg_gnt_i = 0; cfg_r_valid_i = 0;
    endtask

    // Requests HWPE s and runs until it is committed and running (bounded).
    task automatic go_run(input logic s);
        bit done = 0;
        hwpe_en_i = 1; hwpe_sel_i = s;
        for (int c = 0; c < 30 && !done; c++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL go_run cyc%0d: got %b want %b", c, dut_vec, exp_vec());
            end
            done = (cfg_stall_o === 1'b0) && (sel_o === s);
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL go_run timeout: sel %0d never reached RUN", s);
        end
    endtask

    task automatic test_reset();
        rst_i = 1; hwpe_en_i = 0; hwpe_sel_i = 0; idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (dut_vec !== 8'b0000_0100) begin
                miscompares++;
                $display("FAIL reset cyc%0d: got %b want %b", k, dut_vec, 8'b0000_0100);
            end
        end
        rst_i = 0;
    endtask

    task automatic test_bringup();
        hwpe_en_i = 1; hwpe_sel_i = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL bringup cyc%0d: got %b want %b", k, dut_vec, exp_vec());
            end
        end
        // Model reached RUN; confirm the clear already fired once on the way.
        vectors++;
        if (clk_en_o !== 2'b10 || cfg_stall_o !== 1'b0 || clear_o !== 2'b00) begin
            miscompares++;
            $display("FAIL bringup_run: clk_en %b stall %b clear %b, want 10 0 00", clk_en_o, cfg_stall_o, clear_o);
        end
    endtask

    task automatic test_drain_reads();
        go_run(0);
        tcdm_req_i = 1; tcdm_gnt_i = 1; tcdm_wen_i = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL reads cyc%0d: got %b want %b", k, dut_vec, exp_vec());
            end
        end
        idle_inputs();
        hwpe_sel_i = 1;
        for (int k = 0; k < 12; k++) begin
            tcdm_r_valid_i = (k == 5 || k == 6 || k == 9);
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL drain cyc%0d: got %b want %b", k, dut_vec, exp_vec());
            end
            if (k == 9 || k == 10) begin
                vectors++;
                if (clk_en_o !== ((k == 9) ? 2'b01 : 2'b00) || sel_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL drain_gate k%0d: clk_en %b sel %b", k, clk_en_o, sel_o);
                end
            end
        end
        tcdm_r_valid_i = 0;
        vectors++;
        if (sel_o !== 1'b1 || clk_en_o !== 2'b00) begin
            miscompares++;
            $display("FAIL drain_settle: sel %b clk_en %b, want 1 00", sel_o, clk_en_o);
        end
    endtask

    task automatic test_busy_hold();
        go_run(0);
        busy_i = 2'b01; hwpe_sel_i = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL busy cyc%0d: got %b want %b", k, dut_vec, exp_vec());
            end
        end
        vectors++;
        if (clk_en_o !== 2'b01 || cfg_stall_o !== 1'b1 || switching_o !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_hold: clk_en %b stall %b sw %b, want 01 1 1", clk_en_o, cfg_stall_o, switching_o);
        end
        busy_i = 2'b00;
        tick();
        vectors++;
        if (clk_en_o !== 2'b00 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL busy_release: got %b want %b", dut_vec, exp_vec());
        end
    endtask

    task automatic test_cfg_pend();
        go_run(1);
        for (int k = 0; k < 4; k++) begin
            cfg_req_i = (k == 0); cfg_gnt_i = (k == 0); cfg_r_valid_i = (k == 2);
            if (k == 0) hwpe_sel_i = 0;
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL cfg cyc%0d: got %b want %b", k, dut_vec, exp_vec());
            end
            if (k >= 2) begin
                vectors++;
                if (clk_en_o !== ((k == 2) ? 2'b10 : 2'b00)) begin
                    miscompares++;
                    $display("FAIL cfg_wait k%0d: clk_en %b", k, clk_en_o);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_counter();
        go_run(0);
        tcdm_req_i = 1; tcdm_gnt_i = 1; tcdm_wen_i = 1; tcdm_r_valid_i = 1;
        tick();
        vectors++;
        if (outstd_err_o !== 1'b0 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL cnt_incdec: got %b want %b", dut_vec, exp_vec());
        end
        tcdm_r_valid_i = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            vectors++;
            if (outstd_err_o !== ((k == 9) ? 1'b1 : 1'b0) || dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL cnt_read%0d: got %b want %b", k, dut_vec, exp_vec());
            end
        end
        idle_inputs();
        hwpe_sel_i = 1;
        for (int k = 0; k < 9; k++) begin
            tcdm_r_valid_i = (k < 8);
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL cnt_drain cyc%0d: got %b want %b", k, dut_vec, exp_vec());
            end
        end
        tcdm_r_valid_i = 0;
        vectors++;
        if (clk_en_o !== 2'b00 || outstd_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL cnt_sat: clk_en %b err %b, want 00 1", clk_en_o, outstd_err_o);
        end
    endtask

    task automatic test_settle_restart();
        rst_i = 1; tick(); rst_i = 0;
        hwpe_en_i = 1; hwpe_sel_i = 0;
        tick();
        hwpe_sel_i = 1;
        for (int k = 2; k <= 7; k++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL restart cyc%0d: got %b want %b", k, dut_vec, exp_vec());
            end
            if (k == 3 || k == 5 || k == 7) begin
                vectors++;
                if (sel_o !== ((k == 3) ? 1'b1 : 1'b0) || clear_o !== ((k == 7) ? 2'b01 : 2'b00)) begin
                    miscompares++;
                    $display("FAIL restart_sel k%0d: sel %b clear %b", k, sel_o, clear_o);
                end
            end
            if (k == 3) hwpe_sel_i = 0;
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        hwpe_en_i = 1; hwpe_sel_i = 1;
        for (int c = 0; c < 15 && !hit; c++) begin
            tick();
            hit = (sel_o === 1'b1) && (switching_o === 1'b1) && (clk_en_o === 2'b00);
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL rst_settle: SETTLE never reached");
        end
        rst_i = 1; tick(); rst_i = 0;
        vectors++;
        if (dut_vec !== 8'b0000_0100) begin
            miscompares++;
            $display("FAIL rst_settle: got %b want %b", dut_vec, 8'b0000_0100);
        end
        go_run(0);
        busy_i = 2'b01; hwpe_sel_i = 1;
        tick(); tick();
        vectors++;
        if (clk_en_o !== 2'b01 || cfg_stall_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_drain_pre: clk_en %b stall %b", clk_en_o, cfg_stall_o);
        end
        rst_i = 1; tick(); rst_i = 0;
        vectors++;
        if (dut_vec !== 8'b0000_0100) begin
            miscompares++;
            $display("FAIL rst_drain: got %b want %b", dut_vec, 8'b0000_0100);
        end
        busy_i = 0;
    endtask

    task automatic test_random();
        rst_i = 1; tick(); rst_i = 0;
        for (int c = 0; c < 400; c++) begin
            hwpe_en_i = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 11) == 0) hwpe_sel_i = 1'($urandom_range(0, 1));
            busy_i[0]      = ($urandom_range(0, 3) == 0);
            busy_i[1]      = ($urandom_range(0, 3) == 0);
            tcdm_req_i     = (m_outstd < MAXO) && ($urandom_range(0, 1) == 1);
            tcdm_gnt_i     = ($urandom_range(0, 1) == 1);
            tcdm_wen_i     = ($urandom_range(0, 1) == 1);
            tcdm_r_valid_i = (m_outstd > 0) && ($urandom_range(0, 2) == 0);
            cfg_req_i      = ($urandom_range(0, 3) == 0);
            cfg_gnt_i      = ($urandom_range(0, 1) == 1);
            cfg_r_valid_i  = m_pend && ($urandom_range(0, 2) == 0);
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %b want %b", c, dut_vec, exp_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_drain_reads();
        test_busy_hold();
        test_cfg_pend();
        test_counter();
        test_settle_restart();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
